// File: rtl/reset_request_generator_if.sv
// Handshake bundle for reset_request_generator.
//   Local control side : req (in), busy / done / timeout (out)
//   Target side        : target_rst_req (out), target_ack (in, asynchronous loopback)
// master modport is used by the generator; slave modport is the mirror view
// for whatever sits on the other end.
// Optional status (macro RSTGEN_LATENCY_STATUS_EN): ack_latency, last_timeout_phase.
interface reset_request_generator_if;
  logic req;
  logic target_rst_req;
  logic target_ack;
  logic busy;
  logic done;
  logic timeout;
`ifdef RSTGEN_LATENCY_STATUS_EN
  logic [15:0] ack_latency;
  logic [1:0]  last_timeout_phase;

  modport master (
    input  req,
    input  target_ack,
    output target_rst_req,
    output busy,
    output done,
    output timeout,
    output ack_latency,
    output last_timeout_phase
  );

  modport slave (
    output req,
    output target_ack,
    input  target_rst_req,
    input  busy,
    input  done,
    input  timeout,
    input  ack_latency,
    input  last_timeout_phase
  );
`else
  modport master (
    input  req,
    input  target_ack,
    output target_rst_req,
    output busy,
    output done,
    output timeout
  );

  modport slave (
    output req,
    output target_ack,
    input  target_rst_req,
    input  busy,
    input  done,
    input  timeout
  );
`endif
endinterface

// File: rtl/reset_request_generator.sv
// Source-domain reset request generator.
// Drives the reset input of a downstream synchronizer in another clock domain,
// holds it for at least MIN_ASSERT cycles, and waits for the looped-back
// synchronized reset (target_ack) to show the target entering and then leaving
// reset. Each wait phase is bounded by ACK_TIMEOUT cycles.
// Ports:
//   source_clk    - block clock
//   source_rst_n  - asynchronous active-low reset; restarts a full sequence on release
//   bus (master)  - req, target_rst_req, target_ack, busy, done, timeout
// Optional feature macro RSTGEN_LATENCY_STATUS_EN adds bus.ack_latency (cycles spent
// in ASSERT+RELEASE, saturating) and bus.last_timeout_phase (0 none, 1 ASSERT,
// 2 RELEASE).
module reset_request_generator #(
  parameter int unsigned MIN_ASSERT     = 16,
  parameter int unsigned ACK_TIMEOUT    = 256,
  parameter int unsigned ACK_SYNC_DEPTH = 3,
  parameter bit          POLARITY       = 1'b1
) (
  input logic                       source_clk,
  input logic                       source_rst_n,
  reset_request_generator_if.master bus
);

  localparam int unsigned     CntW    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] MinLast = CntW'(MIN_ASSERT - 1);
  localparam logic [CntW-1:0] ToLast  = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAssert, StRelease, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      rst_req_q, rst_req_d;
  logic [ACK_SYNC_DEPTH-1:0] ack_sync_q;
  logic                      ack_s;
  logic                      ack_active;
  logic                      done_int;
  logic                      timeout_pulse;

  // Synchronizer resets to the active level so the power-on sequence behaves as
  // if the target is already in reset.
  always_ff @(posedge source_clk or negedge source_rst_n) begin
    if (!source_rst_n) begin
      ack_sync_q <= {ACK_SYNC_DEPTH{POLARITY}};
    end else begin
      ack_sync_q <= {ack_sync_q[ACK_SYNC_DEPTH-2:0], bus.target_ack};
    end
  end

  assign ack_s      = ack_sync_q[ACK_SYNC_DEPTH-1];
  assign ack_active = (ack_s == POLARITY);

  // Next state. The normal exit is tested before the timeout so it wins when
  // both hold in the same cycle.
  always_comb begin
    state_d       = state_q;
    timeout_pulse = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) state_d = StAssert;
      end
      StAssert: begin
        if (cnt_q >= MinLast && ack_active) begin
          state_d = StRelease;
        end else if (cnt_q == ToLast) begin
          state_d       = StIdle;
          timeout_pulse = 1'b1;
        end
      end
      StRelease: begin
        if (!ack_active) begin
          state_d = StDone;
        end else if (cnt_q == ToLast) begin
          state_d       = StIdle;
          timeout_pulse = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Counter restarts on every state change and only runs in the wait phases.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {StAssert, StRelease}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Request is registered from the next state so the pin comes straight off a flop.
  assign rst_req_d = (state_d == StAssert) ? POLARITY : ~POLARITY;

  always_ff @(posedge source_clk or negedge source_rst_n) begin
    if (!source_rst_n) begin
      state_q   <= StAssert;
      cnt_q     <= '0;
      rst_req_q <= POLARITY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_req_q <= rst_req_d;
    end
  end

  assign done_int           = (state_q == StDone);
  assign bus.target_rst_req = rst_req_q;
  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = done_int;
  assign bus.timeout        = timeout_pulse;

`ifdef RSTGEN_LATENCY_STATUS_EN
  logic [15:0] lat_cnt_q, lat_cnt_d;
  logic [15:0] ack_latency_q, ack_latency_d;
  logic [1:0]  phase_q, phase_d;

  // lat_cnt_d already includes the timeout cycle itself, while on the done cycle
  // it holds the ASSERT+RELEASE total, so both events latch the same signal.
  always_comb begin
    lat_cnt_d     = lat_cnt_q;
    ack_latency_d = ack_latency_q;
    phase_d       = phase_q;
    if (state_q != StAssert && state_d == StAssert) begin
      lat_cnt_d = '0;
    end else if ((state_q == StAssert || state_q == StRelease) && lat_cnt_q != 16'hFFFF) begin
      lat_cnt_d = lat_cnt_q + 16'd1;
    end
    if (done_int) begin
      ack_latency_d = lat_cnt_d;
      phase_d       = 2'd0;
    end else if (timeout_pulse) begin
      ack_latency_d = lat_cnt_d;
      phase_d       = (state_q == StAssert) ? 2'd1 : 2'd2;
    end
  end

  always_ff @(posedge source_clk or negedge source_rst_n) begin
    if (!source_rst_n) begin
      lat_cnt_q     <= '0;
      ack_latency_q <= '0;
      phase_q       <= '0;
    end else begin
      lat_cnt_q     <= lat_cnt_d;
      ack_latency_q <= ack_latency_d;
      phase_q       <= phase_d;
    end
  end

  assign bus.ack_latency        = ack_latency_q;
  assign bus.last_timeout_phase = phase_q;
`endif

endmodule

// File: tb/tb_reset_request_generator.sv
// Self-checking bench for reset_request_generator.
// target_ack is a scripted waveform relative to ASSERT entry: active for cycles
// [wave_a, wave_f). The reference model derives the whole sequence from the
// rules: ack_s is that waveform seen SyncDepth-1 cycles late, ASSERT ends at the
// first cycle >= MinAssert-1 with ack_s active, RELEASE ends at the first cycle
// with ack_s inactive, each phase capped at AckTimeout cycles.
module tb_reset_request_generator;

  localparam int MinAssert  = 16;
  localparam int AckTimeout = 64;
  localparam int SyncDepth  = 3;
  localparam bit Pol        = 1'b1;

  logic source_clk = 1'b0;
  logic source_rst_n = 1'b1;

  reset_request_generator_if bus ();

  reset_request_generator #(
    .MIN_ASSERT    (MinAssert),
    .ACK_TIMEOUT   (AckTimeout),
    .ACK_SYNC_DEPTH(SyncDepth),
    .POLARITY      (Pol)
  ) dut (
    .source_clk  (source_clk),
    .source_rst_n(source_rst_n),
    .bus         (bus)
  );

  always #5 source_clk = ~source_clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  bit wave_pre;
  int wave_a;
  int wave_f;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // target_ack level sampled at the k-th edge after ASSERT entry
  function automatic bit wave(input int k);
    if (k < 0) return wave_pre;
    return (k >= wave_a && k < wave_f) ? Pol : !Pol;
  endfunction

  function automatic bit acks(input int j);
    return wave(j - (SyncDepth - 1)) == Pol;
  endfunction

  function automatic void predict(output int assert_last, output int end_cyc,
                                  output bit ok, output int to_phase);
    int x = -1;
    int r = -1;
    for (int j = MinAssert - 1; j <= AckTimeout - 1 && x < 0; j++) if (acks(j)) x = j;
    if (x < 0) begin
      assert_last = AckTimeout - 1;
      end_cyc     = AckTimeout - 1;
      ok          = 1'b0;
      to_phase    = 1;
      return;
    end
    assert_last = x;
    for (int i = 0; i < AckTimeout && r < 0; i++) if (!acks(x + 1 + i)) r = i;
    if (r < 0) begin
      end_cyc  = x + AckTimeout;
      ok       = 1'b0;
      to_phase = 2;
    end else begin
      end_cyc  = x + 2 + r;
      ok       = 1'b1;
      to_phase = 0;
    end
  endfunction

  // power_on: sequence starts by releasing source_rst_n (caller holds it low, wave_a = 0).
  // Otherwise: idle the ack, then pulse req. extra_req: cycle for an ignored req pulse.
  task automatic run_seq(input bit power_on, input int a, input int f, input int extra_req);
    int al, ec, ph, xr;
    bit ok;
    wave_pre = power_on ? Pol : !Pol;
    wave_a   = a;
    wave_f   = f;
    predict(al, ec, ok, ph);
    xr = (extra_req >= 1 && extra_req <= ec) ? extra_req : -1;
    if (!power_on) begin
      bus.target_ack = !Pol;
      repeat (SyncDepth + 1) @(negedge source_clk);
      bus.req        = 1'b1;
      bus.target_ack = wave(0);
    end
    for (int k = 0; k <= ec + 3; k++) begin
      @(negedge source_clk);
      if (power_on && k == 0) source_rst_n = 1'b1;
      bus.req        = (k == xr);
      bus.target_ack = wave(k + 1);
      #1;
      check($sformatf("rst_req a=%0d f=%0d c=%0d", a, f, k), bus.target_rst_req,
            (k <= al) ? Pol : !Pol);
      check($sformatf("busy a=%0d f=%0d c=%0d", a, f, k), bus.busy, k <= ec);
      check($sformatf("done a=%0d f=%0d c=%0d", a, f, k), bus.done, ok && k == ec);
      check($sformatf("timeout a=%0d f=%0d c=%0d", a, f, k), bus.timeout, !ok && k == ec);
    end
`ifdef RSTGEN_LATENCY_STATUS_EN
    check($sformatf("ack_latency a=%0d f=%0d", a, f), bus.ack_latency, ok ? ec : ec + 1);
    check($sformatf("last_phase a=%0d f=%0d", a, f), bus.last_timeout_phase, ph);
`endif
  endtask

  initial begin
    bus.req        = 1'b0;
    bus.target_ack = Pol;
    #2 source_rst_n = 1'b0;
    #1;
    check("reset rst_req", bus.target_rst_req, Pol);
    check("reset busy", bus.busy, 1'b1);
    check("reset done", bus.done, 1'b0);
    check("reset timeout", bus.timeout, 1'b0);
`ifdef RSTGEN_LATENCY_STATUS_EN
    check("reset ack_latency", bus.ack_latency, 16'd0);
    check("reset last_phase", bus.last_timeout_phase, 2'd0);
`endif
    repeat (3) @(negedge source_clk);

    // power-on with a healthy loopback
    run_seq(1'b1, 0, 20, -1);
    // software request, plus an ignored req while busy
    run_seq(1'b0, 5, 40, 10);
    // ack stuck inactive: timeout in ASSERT
    run_seq(1'b0, 1000000, 1000001, 30);
    // ack stuck active: timeout in RELEASE
    run_seq(1'b0, 0, 1000000, -1);
    // exit on the last ASSERT cycle beats the timeout
    run_seq(1'b0, 61, 100, -1);
    // exit on the last RELEASE cycle beats the timeout
    run_seq(1'b0, 0, 77, -1);
    // one cycle later: RELEASE timeout
    run_seq(1'b0, 0, 78, -1);
    // ack pulse gone before the minimum width elapses
    run_seq(1'b0, 0, 10, -1);

    for (int n = 0; n < 12; n++) begin
      int a, f;
      a = int'($urandom_range(0, 70));
      f = a + int'($urandom_range(1, 110));
      run_seq(1'b0, a, f, int'($urandom_range(1, 60)));
    end

    // asynchronous reset while in RELEASE
    @(negedge source_clk);
    bus.target_ack = !Pol;
    repeat (SyncDepth + 1) @(negedge source_clk);
    bus.req        = 1'b1;
    bus.target_ack = Pol;
    @(negedge source_clk);
    bus.req = 1'b0;
    repeat (20) @(negedge source_clk);
    #1;
    check("mid rst_req before", bus.target_rst_req, !Pol);
    check("mid busy before", bus.busy, 1'b1);
    @(posedge source_clk);
    #2 source_rst_n = 1'b0;
    #1;
    check("mid rst_req async", bus.target_rst_req, Pol);
    check("mid busy async", bus.busy, 1'b1);
    check("mid done async", bus.done, 1'b0);
    check("mid timeout async", bus.timeout, 1'b0);
    repeat (2) @(negedge source_clk);
    run_seq(1'b1, 0, 30, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
